// File: rtl/viterbi_traceback_multi.sv
// Traceback and output-decision unit for a hard-decision Viterbi decoder.
// Buffers one survivor vector per trellis step and traces back from the best state at frame end.
module viterbi_traceback_multi #(
    parameter int K        = 3,
    parameter int TB_DEPTH = 8,
    parameter int LW       = $clog2(TB_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_dec_valid,
    input  logic [(1<<(K-1))-1:0] i_dec,
    input  logic                  i_last,
    input  logic [K-2:0]          i_best_state,
    output logic                  o_ready,
    output logic                  o_valid,
    input  logic                  i_out_ready,
    output logic [TB_DEPTH-1:0]   o_data,
    output logic [LW-1:0]         o_len,
    output logic                  o_trunc,
    output logic                  o_busy
);
    localparam int SW = K - 1;
    localparam int NS = 1 << SW;
    localparam int CW = $clog2(TB_DEPTH);

    typedef enum logic [1:0] {FILL, TRACE, HOLD} state_t;

    state_t state, state_next;

    logic [CW-1:0]       step_cnt;
    logic [CW-1:0]       t_idx;
    logic [SW-1:0]       cur_state;
    logic [LW-1:0]       len;
    logic                trunc;
    logic [TB_DEPTH-1:0] shreg;
    logic [TB_DEPTH-1:0] shreg_upd;
    logic [NS-1:0]       mem [TB_DEPTH];
    logic                accept;
    logic                at_limit;
    logic                close_frame;

    assign o_ready     = (state == FILL);
    assign o_busy      = (state != FILL);
    assign accept      = i_dec_valid && o_ready;
    assign at_limit    = (step_cnt == CW'(TB_DEPTH - 1));
    assign close_frame = accept && (i_last || at_limit);

    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (close_frame) state_next = TRACE;
            TRACE:   if (t_idx == '0) state_next = HOLD;
            HOLD:    if (i_out_ready) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // The bit decided this cycle is merged in so the last step can load o_data directly.
    always_comb begin
        shreg_upd        = shreg;
        shreg_upd[t_idx] = cur_state[SW-1];
    end

    // Survivor memory has no reset; entries are always written before they are traced.
    always_ff @(posedge clk) begin
        if (accept) mem[step_cnt] <= i_dec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt  <= '0;
            t_idx     <= '0;
            cur_state <= '0;
            len       <= '0;
            trunc     <= 1'b0;
            shreg     <= '0;
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_len     <= '0;
            o_trunc   <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) step_cnt <= step_cnt + 1'b1;
                    if (close_frame) begin
                        cur_state <= i_best_state;
                        len       <= LW'(step_cnt) + 1'b1;
                        t_idx     <= step_cnt;
                        trunc     <= !i_last;
                        shreg     <= '0;
                    end
                end
                TRACE: begin
                    shreg     <= shreg_upd;
                    cur_state <= {cur_state[SW-2:0], mem[t_idx][cur_state]};
                    t_idx     <= t_idx - 1'b1;
                    if (t_idx == '0) begin
                        o_data  <= shreg_upd;
                        o_len   <= len;
                        o_trunc <= trunc;
                        o_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (i_out_ready) begin
                        o_valid  <= 1'b0;
                        step_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_viterbi_traceback_multi.sv
// Directed bench: K=3/depth-8 instance for the main cases, K=5/depth-16 instance for the sweep.
module tb_viterbi_traceback_multi;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // K=3, TB_DEPTH=8
    logic       rst, dv, last, ordy, ov, ordy_in, otrunc, obusy;
    logic [3:0] dec;
    logic [1:0] best;
    logic [7:0] odata;
    logic [3:0] olen;

    // K=5, TB_DEPTH=16
    logic        b_rst, b_dv, b_last, b_ordy, b_ov, b_ordy_in, b_otrunc, b_obusy;
    logic [15:0] b_dec;
    logic [3:0]  b_best;
    logic [15:0] b_odata;
    logic [4:0]  b_olen;

    int checks = 0;
    int errors = 0;

    viterbi_traceback_multi #(.K(3), .TB_DEPTH(8)) dut_a (
        .clk(clk), .rst(rst), .i_dec_valid(dv), .i_dec(dec), .i_last(last),
        .i_best_state(best), .o_ready(ordy), .o_valid(ov), .i_out_ready(ordy_in),
        .o_data(odata), .o_len(olen), .o_trunc(otrunc), .o_busy(obusy)
    );

    viterbi_traceback_multi #(.K(5), .TB_DEPTH(16)) dut_b (
        .clk(clk), .rst(b_rst), .i_dec_valid(b_dv), .i_dec(b_dec), .i_last(b_last),
        .i_best_state(b_best), .o_ready(b_ordy), .o_valid(b_ov), .i_out_ready(b_ordy_in),
        .o_data(b_odata), .o_len(b_olen), .o_trunc(b_otrunc), .o_busy(b_obusy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives n beats on dut_a; decision of the on-path state is the bit shifted out of the encoder.
    task automatic run_a(input logic [7:0] bits, input int n, input bit fin, input bit rnd);
        logic [1:0] st, prev;
        st = '0;
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            prev = st;
            st   = {bits[t], st[1]};
            dec  = rnd ? 4'($urandom) : 4'h0;
            dec[st] = prev[0];
            last = fin && (t == n - 1);
            best = st;
            dv   = 1'b1;
        end
    endtask

    task automatic run_b(input logic [15:0] bits, input int n);
        logic [3:0] st, prev;
        st = '0;
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            prev  = st;
            st    = {bits[t], st[3:1]};
            b_dec = 16'($urandom);
            b_dec[st] = prev[0];
            b_last = (t == n - 1);
            b_best = st;
            b_dv   = 1'b1;
        end
    endtask

    // Counts falling edges until o_valid, bounded; drop releases the beat after the first edge.
    task automatic wait_a(input bit drop, output int n);
        n = 0;
        while (ov !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
            if (drop) begin dv = 1'b0; last = 1'b0; end
        end
    endtask

    task automatic wait_b(output int n);
        n = 0;
        while (b_ov !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
            b_dv = 1'b0; b_last = 1'b0;
        end
    endtask

    initial begin
        int n;
        logic [15:0] stream;
        logic [4:0]  short5;

        rst = 1'b1; b_rst = 1'b1;
        dv = 0; dec = 0; last = 0; best = 0; ordy_in = 0;
        b_dv = 0; b_dec = 0; b_last = 0; b_best = 0; b_ordy_in = 1;
        repeat (2) begin
            @(negedge clk);
            dv = 1'($urandom); dec = 4'($urandom); last = 1'($urandom);
            best = 2'($urandom); ordy_in = 1'($urandom);
            b_dv = 1'($urandom); b_dec = 16'($urandom); b_last = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_valid", ov, 0);
        chk("rst_data", odata, 0);
        chk("rst_len", olen, 0);
        chk("rst_trunc", otrunc, 0);
        chk("rst_busy", obusy, 0);
        chk("rst_ready", ordy, 1);
        chk("rst_b_valid", b_ov, 0);
        chk("rst_b_ready", b_ordy, 1);
        rst = 0; b_rst = 0;
        dv = 0; last = 0; ordy_in = 0; b_dv = 0; b_last = 0;

        // Known path b=1,0,1,1,0,0,1,0, then backpressure
        run_a(8'b01001101, 8, 1'b1, 1'b1);
        chk("known_best", best, 2'b01);
        wait_a(1'b1, n);
        chk("known_latency", n, 9);
        chk("known_data", odata, 8'b01001101);
        chk("known_len", olen, 8);
        chk("known_trunc", otrunc, 0);
        chk("known_busy", obusy, 1);
        for (int i = 0; i < 5; i++) begin
            dv = 1'b1;
            chk("bp_valid", ov, 1);
            chk("bp_data", odata, 8'b01001101);
            chk("bp_ready", ordy, 0);
            @(negedge clk);
        end
        dv = 1'b0;
        ordy_in = 1'b1;
        @(negedge clk);
        chk("bp_rel_valid", ov, 0);
        chk("bp_rel_ready", ordy, 1);

        // Short frame, single-cycle o_valid pulse
        run_a(8'b00000100, 3, 1'b1, 1'b0);
        chk("short_best", best, 2'b10);
        wait_a(1'b1, n);
        chk("short_latency", n, 4);
        chk("short_data", odata, 8'b00000100);
        chk("short_len", olen, 3);
        chk("short_trunc", otrunc, 0);
        @(negedge clk);
        chk("short_pulse", ov, 0);
        chk("short_ready", ordy, 1);

        // Truncation: no i_last, 9th beat must stall and survive into the next frame
        ordy_in = 1'b0;
        run_a(8'h00, 8, 1'b0, 1'b0);
        @(negedge clk);
        chk("trunc_stall", ordy, 0);
        dv = 1'b1; dec = 4'hF; last = 1'b1; best = 2'b11;
        n = 1;
        while (ov !== 1'b1 && n < 64) begin @(negedge clk); n++; end
        chk("trunc_latency", n, 9);
        chk("trunc_flag", otrunc, 1);
        chk("trunc_len", olen, 8);
        chk("trunc_data", odata, 0);
        ordy_in = 1'b1;
        @(negedge clk);
        chk("held_beat_ready", ordy, 1);
        wait_a(1'b1, n);
        chk("held_beat_latency", n, 2);
        chk("held_beat_data", odata, 8'h01);
        chk("held_beat_len", olen, 1);
        chk("held_beat_trunc", otrunc, 0);

        // K=5, depth 16: full random frame
        stream = 16'($urandom);
        run_b(stream, 16);
        wait_b(n);
        chk("b_latency", n, 17);
        chk("b_data", b_odata, stream);
        chk("b_len", b_olen, 16);
        chk("b_trunc", b_otrunc, 0);
        @(negedge clk);
        chk("b_pulse", b_ov, 0);

        // Reset during TRACE, then a clean short frame
        run_b(16'($urandom), 10);
        @(negedge clk);
        b_dv = 1'b0; b_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("b_mid_busy", b_obusy, 1);
        b_rst = 1'b1;
        @(negedge clk);
        b_rst = 1'b0;
        chk("b_rst_valid", b_ov, 0);
        chk("b_rst_busy", b_obusy, 0);
        chk("b_rst_ready", b_ordy, 1);
        repeat (12) @(negedge clk);
        chk("b_rst_no_output", b_ov, 0);
        short5 = 5'($urandom);
        run_b({11'b0, short5}, 5);
        wait_b(n);
        chk("b_clean_latency", n, 6);
        chk("b_clean_data", b_odata, {11'b0, short5});
        chk("b_clean_len", b_olen, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
